// File: rtl/sprite_line_walker.sv
// Walks one latched sprite-line descriptor pixel by pixel and streams candidate
// pixels (screen X, opacity, tile address/subpixel) over a valid/ready handshake.
module sprite_line_walker #(
    parameter int SPRITE_WIDTH     = 32,
    parameter int X_WIDTH          = 10,
    parameter int ADDR_WIDTH       = 16,
    parameter int TILE_WIDTH       = 8,
    parameter int SCREEN_WIDTH     = 640,
    parameter int SKIP_TRANSPARENT = 0
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic                           i_start,
    input  logic                           i_abort,
    input  logic [SPRITE_WIDTH-1:0]        i_sprite_line_mask,
    input  logic [ADDR_WIDTH-1:0]          i_sprite_line_address,
    input  logic [X_WIDTH-1:0]             i_sprite_start_x,
    input  logic                           i_tile_row,
    input  logic                           i_row_flip,
    input  logic                           i_col_flip,
    output logic                           o_busy,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [X_WIDTH-1:0]             o_x,
    output logic                           o_visible,
    output logic [ADDR_WIDTH-1:0]          o_tile_address,
    output logic [$clog2(TILE_WIDTH):0]    o_tile_subpixel,
    output logic                           o_done
);

    localparam int IDX_W  = $clog2(SPRITE_WIDTH);
    localparam int TW_LOG = $clog2(TILE_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    state_r;
    state_t                    state_next_s;
    logic [IDX_W-1:0]          idx_r;
    logic [SPRITE_WIDTH-1:0]   mask_r;
    logic [ADDR_WIDTH-1:0]     addr_r;
    logic [X_WIDTH-1:0]        start_x_r;
    logic                      row_r;
    logic                      col_flip_r;

    logic [IDX_W-1:0]          col_s;
    logic [X_WIDTH:0]          x_s;
    logic                      clip_s;
    logic                      vis_s;
    logic                      emit_s;
    logic                      run_s;
    logic                      retire_s;
    logic                      last_s;

    // Extra X bit keeps a carry out visible so it clips instead of wrapping to 0.
    assign col_s    = col_flip_r ? (IDX_W'(SPRITE_WIDTH - 1) - idx_r) : idx_r;
    assign x_s      = {1'b0, start_x_r} + (X_WIDTH + 1)'(idx_r);
    assign clip_s   = (x_s >= (X_WIDTH + 1)'(SCREEN_WIDTH));
    assign vis_s    = mask_r[col_s];
    assign emit_s   = !clip_s && (vis_s || (SKIP_TRANSPARENT == 0));
    assign run_s    = (state_r == ST_RUN);
    assign retire_s = run_s && (!emit_s || i_ready);
    assign last_s   = (idx_r == IDX_W'(SPRITE_WIDTH - 1));

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; abort wins over line completion
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) state_next_s = ST_RUN;
                else         state_next_s = ST_IDLE;
            end
            ST_RUN: begin
                if (i_abort)                 state_next_s = ST_IDLE;
                else if (retire_s && last_s) state_next_s = ST_DONE;
                else                         state_next_s = ST_RUN;
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Descriptor latch and pixel index
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            idx_r      <= {IDX_W{1'b0}};
            mask_r     <= {SPRITE_WIDTH{1'b0}};
            addr_r     <= {ADDR_WIDTH{1'b0}};
            start_x_r  <= {X_WIDTH{1'b0}};
            row_r      <= 1'b0;
            col_flip_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && i_start) begin
            idx_r      <= {IDX_W{1'b0}};
            mask_r     <= i_sprite_line_mask;
            addr_r     <= i_sprite_line_address;
            start_x_r  <= i_sprite_start_x;
            row_r      <= i_tile_row ^ i_row_flip;
            col_flip_r <= i_col_flip;
        end else if (retire_s && !last_s) begin
            idx_r      <= idx_r + IDX_W'(1);
        end else begin
            idx_r      <= idx_r;
        end
    end

    // Outputs derive only from registered state; data is zeroed outside RUN
    always_comb begin
        o_busy          = (state_r != ST_IDLE);
        o_done          = (state_r == ST_DONE);
        o_valid         = run_s && emit_s;
        o_x             = {X_WIDTH{1'b0}};
        o_visible       = 1'b0;
        o_tile_address  = {ADDR_WIDTH{1'b0}};
        o_tile_subpixel = {(TW_LOG + 1){1'b0}};
        if (run_s) begin
            o_x             = x_s[X_WIDTH-1:0];
            o_visible       = vis_s;
            o_tile_address  = addr_r + ADDR_WIDTH'(col_s >> TW_LOG);
            o_tile_subpixel = {row_r, col_s[TW_LOG-1:0]};
        end else begin
            o_x             = {X_WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_sprite_line_walker.sv
// Randomised/directed bench: two walkers (transparent pixels emitted / skipped) share
// stimulus; each is scored against beat lists computed directly from the pixel rules.
module tb_sprite_line_walker;

    localparam int SW  = 32;
    localparam int TW  = 8;
    localparam int SCR = 640;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, ready, trow, rflip, cflip;
    logic [31:0] mask;
    logic [15:0] addr;
    logic [9:0]  sx;

    logic        busy0, valid0, vis0, done0, busy1, valid1, vis1, done1;
    logic [9:0]  x0, x1;
    logic [15:0] ta0, ta1;
    logic [3:0]  sub0, sub1;

    typedef struct packed {
        logic [9:0]  x;
        logic        vis;
        logic [15:0] addr;
        logic [3:0]  sub;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    int    stalls[2];
    bit    done_seen[2];
    bit    prev_stall[2];
    beat_t prev_beat[2];
    int    cyc;
    int    vectors = 0;
    int    miscompares = 0;

    always #5 clk = ~clk;

    sprite_line_walker #(.SKIP_TRANSPARENT(0)) u_emit (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_abort(abort),
        .i_sprite_line_mask(mask), .i_sprite_line_address(addr), .i_sprite_start_x(sx),
        .i_tile_row(trow), .i_row_flip(rflip), .i_col_flip(cflip),
        .o_busy(busy0), .o_valid(valid0), .i_ready(ready), .o_x(x0), .o_visible(vis0),
        .o_tile_address(ta0), .o_tile_subpixel(sub0), .o_done(done0));

    sprite_line_walker #(.SKIP_TRANSPARENT(1)) u_skip (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_abort(abort),
        .i_sprite_line_mask(mask), .i_sprite_line_address(addr), .i_sprite_start_x(sx),
        .i_tile_row(trow), .i_row_flip(rflip), .i_col_flip(cflip),
        .o_busy(busy1), .o_valid(valid1), .i_ready(ready), .o_x(x1), .o_visible(vis1),
        .o_tile_address(ta1), .o_tile_subpixel(sub1), .o_done(done1));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected beat lists for both walkers, straight from the per-pixel rules
    function automatic void build_model(input logic [31:0] m, input logic [15:0] a,
                                        input logic [9:0] s, input logic tr, rf, cf);
        q0.delete();
        q1.delete();
        for (int p = 0; p < SW; p++) begin
            int    c;
            int    x;
            beat_t b;
            c = cf ? (SW - 1 - p) : p;
            x = int'(s) + p;
            if (x >= SCR) continue;
            b.x    = x[9:0];
            b.vis  = m[c];
            b.addr = a + 16'(c / TW);
            b.sub  = {tr ^ rf, 3'(c % TW)};
            q0.push_back(b);
            if (b.vis) q1.push_back(b);
        end
    endfunction

    task automatic observe(input int d, input logic v, input beat_t b, input logic dn, input logic bz);
        beat_t e;
        if (prev_stall[d]) begin
            check($sformatf("stall_valid%0d", d), 64'(v), 64'd1);
            check($sformatf("stall_hold%0d", d), 64'(b), 64'(prev_beat[d]));
        end
        if (!done_seen[d]) check($sformatf("busy%0d", d), 64'(bz), 64'd1);
        if (v && ready) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                check($sformatf("extra_beat%0d", d), 64'(v), 64'd0);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check($sformatf("beat%0d", d), 64'(b), 64'(e));
            end
        end
        if (dn) begin
            check($sformatf("done_twice%0d", d), 64'(done_seen[d]), 64'd0);
            check($sformatf("done_cycle%0d", d), 64'(cyc), 64'(SW + 1 + stalls[d]));
            done_seen[d] = 1'b1;
        end
        prev_stall[d] = v && !ready;
        prev_beat[d]  = b;
        if (v && !ready) stalls[d]++;
    endtask

    task automatic run_line(input logic [31:0] m, input logic [15:0] a, input logic [9:0] s,
                            input logic tr, rf, cf, input bit rnd_ready, input bit poke_start);
        build_model(m, a, s, tr, rf, cf);
        stalls     = '{0, 0};
        done_seen  = '{1'b0, 1'b0};
        prev_stall = '{1'b0, 1'b0};
        @(posedge clk); #1;
        mask = m; addr = a; sx = s; trow = tr; rflip = rf; cflip = cf; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        cyc = 0;
        while (!(done_seen[0] && done_seen[1]) && cyc < 300) begin
            @(negedge clk);
            cyc++;
            observe(0, valid0, {x0, vis0, ta0, sub0}, done0, busy0);
            observe(1, valid1, {x1, vis1, ta1, sub1}, done1, busy1);
            // A start while both walkers are busy must not disturb the current line
            if (poke_start && busy0 && busy1 && $urandom_range(0, 3) == 0) begin
                start = 1'b1;
                mask  = $urandom;
                addr  = 16'($urandom);
                sx    = 10'($urandom);
                cflip = ~cflip;
            end
            @(posedge clk); #1;
            start = 1'b0;
            ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        check("done_seen0", 64'(done_seen[0]), 64'd1);
        check("done_seen1", 64'(done_seen[1]), 64'd1);
        check("beats_left0", 64'(q0.size()), 64'd0);
        check("beats_left1", 64'(q1.size()), 64'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "0"}, 64'({valid0, busy0, done0, x0, vis0, ta0, sub0}), 64'd0);
        check({tag, "1"}, 64'({valid1, busy1, done1, x1, vis1, ta1, sub1}), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0;
        trow = 1'b0; rflip = 1'b0; cflip = 1'b0;
        mask = 32'h0; addr = 16'h0; sx = 10'h0;
        #12;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_line(32'hFFFF_FFFF, 16'h1000, 10'd100,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_line(32'hFFFF_FFFF, 16'h1000, 10'd100,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_line(32'hFFFF_FFFF, 16'h1000, 10'd630,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_line(32'hFFFF_FFFF, 16'hFFFE, 10'd1020, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_line(32'h8000_0001, 16'h1234, 10'd200,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_line(32'h8000_0001, 16'hFFFD, 10'd615,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            run_line($urandom, 16'($urandom), 10'($urandom_range(0, 700)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'b1, 1'b1);
        end

        // Abort mid-line, with a start that must be ignored in the same cycle
        @(posedge clk); #1;
        mask = 32'hFFFF_FFFF; addr = 16'h2000; sx = 10'd10; ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        @(negedge clk);
        check_idle("abort");
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("abort_no_done", 64'({done0, done1, busy0, busy1}), 64'd0);
        end

        // Reset asserted mid-line
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("reset_no_done", 64'({done0, done1, busy0, busy1}), 64'd0);
        end

        run_line(32'hA5A5_3C3C, 16'h0042, 10'd300, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
